// File: rtl/kb_pkg.sv
// Shared constants and helpers for the keyboard FIFO and its benches.
package kb_pkg;

  localparam int unsigned KB_IN_W   = 8;
  localparam int unsigned KB_DATA_W = 7;
  localparam int unsigned KB_DEPTH  = 16;

  localparam logic [6:0] KB_CHAR_SPACE = 7'h20;
  localparam logic [6:0] KB_CHAR_CR    = 7'h0D;
  localparam logic [6:0] KB_CHAR_A     = 7'h41;

  // Occupancy counter must hold the value DEPTH itself.
  function automatic int unsigned kb_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/kb_fifo_if.sv
// Receiver/CPU-side handshake bundle of the keyboard FIFO.
interface kb_fifo_if
  import kb_pkg::*;
#(
  parameter int unsigned IN_W   = KB_IN_W,
  parameter int unsigned DATA_W = KB_DATA_W,
  parameter int unsigned DEPTH  = KB_DEPTH
) ();

  localparam int unsigned CW = kb_cnt_w(DEPTH);

  logic              KB_clear;
  logic              write;
  logic [IN_W-1:0]   write_data;
  logic              KB_read_en;
  logic [DATA_W-1:0] read_data;
  logic              KB_status;
  logic              buf_full;
  logic              almost_full;
  logic [CW-1:0]     count;
  logic              overflow;

  modport master (
    output KB_clear, write, write_data, KB_read_en,
    input  read_data, KB_status, buf_full, almost_full, count, overflow
  );

  modport slave (
    input  KB_clear, write, write_data, KB_read_en,
    output read_data, KB_status, buf_full, almost_full, count, overflow
  );

endinterface

// File: rtl/kb_fifo_mem.sv
// DEPTH x DATA_W register file: one synchronous write port, one asynchronous read port.
module kb_fifo_mem
  import kb_pkg::*;
#(
  parameter int unsigned DATA_W = KB_DATA_W,
  parameter int unsigned DEPTH  = KB_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/kb_fifo.sv
// Keyboard character FIFO with occupancy, almost-full and sticky overflow.
// Define KB_OVERWRITE_EN to overwrite the oldest entry on a full write instead of dropping.
module kb_fifo
  import kb_pkg::*;
#(
  parameter int unsigned IN_W   = KB_IN_W,
  parameter int unsigned DATA_W = KB_DATA_W,
  parameter int unsigned DEPTH  = KB_DEPTH,
  parameter int unsigned AF_LVL = DEPTH - 2
) (
  input logic      clk,
  input logic      rst_n,
  kb_fifo_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = kb_cnt_w(DEPTH);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] AfLvlC = CW'(AF_LVL);

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_ovw;
  logic              w_lost;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DepthC);
  assign w_pop   = bus.KB_read_en && !w_empty;
  // A pop in the same cycle frees the slot a full-FIFO write needs.
  assign w_push  = bus.write && (!w_full || w_pop);
  assign w_lost  = bus.write && w_full && !w_pop;

`ifdef KB_OVERWRITE_EN
  assign w_ovw = w_lost;
`else
  assign w_ovw = 1'b0;
`endif

  assign w_we = !bus.KB_clear && (w_push || w_ovw);

  kb_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.write_data[DATA_W-1:0]),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (bus.KB_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push || w_ovw) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop || w_ovw) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_lost) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.read_data   = w_empty ? '0 : w_rdata;
  assign bus.KB_status   = !w_empty;
  assign bus.buf_full    = w_full;
  assign bus.almost_full = (r_count >= AfLvlC);
  assign bus.count       = r_count;
  assign bus.overflow    = r_overflow;

  generate
    if (IN_W > DATA_W) begin : g_discard
      logic w_unused_hi;
      assign w_unused_hi = ^bus.write_data[IN_W-1:DATA_W];
    end
  endgenerate

endmodule
